// File: rtl/axi_pkg.sv
// Shared AXI4-Lite constants for the core-side bridge and the memory-mapped peripherals.
// Response codes, peripheral addresses and a small response-decode helper.
package axi_pkg;

   localparam logic [1:0] AXI_OKAY   = 2'b00;
   localparam logic [1:0] AXI_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_SLVERR = 2'b10;
   localparam logic [1:0] AXI_DECERR = 2'b11;

   localparam logic [31:0] LED_ADDR = 32'h0000_00FF;

   // Anything other than OKAY is reported to the core as an error (EXOKAY included,
   // since AXI4-Lite has no exclusive accesses).
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != AXI_OKAY;
   endfunction

endpackage

// File: rtl/axi_intf.sv
// AXI4-Lite channel bundle (AW/W/B/AR/R) clocked by aclk.
// Valid/ready rule on every channel: a transfer happens on a rising aclk edge where
// valid & ready are both 1; once valid is raised it and its payload hold until that edge.
interface axi_intf #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic aclk
);

   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;

   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;

   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;

   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      input  aclk,
      output awaddr, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready,
      output araddr, arprot, arvalid,
      input  arready,
      input  rdata, rresp, rvalid,
      output rready
   );

   modport slave (
      input  aclk,
      input  awaddr, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready,
      input  araddr, arprot, arvalid,
      output arready,
      output rdata, rresp, rvalid,
      input  rready
   );

endinterface

// File: rtl/axi_lite_master_bridge.sv
// Turns the core's single-outstanding load/store port into AXI4-Lite master transfers.
// One transaction in flight; each accepted request yields exactly one rsp_valid pulse.
module axi_lite_master_bridge
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int CHECK_ALIGN = 0
) (
   input  logic                    aclk,
   input  logic                    aresetn,

   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,

   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,

   output logic [2:0]              dbg_state,

   axi_intf.master                 axi
);

   localparam int STRB_W = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t                state, state_nxt;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]     wstrb_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;
   logic                  aw_done;
   logic                  w_done;

   logic                  accept;
   logic                  misaligned;
   logic                  aw_hs;
   logic                  w_hs;

   assign accept     = req_valid & req_ready;
   assign misaligned = (CHECK_ALIGN != 0) && (req_addr[1:0] != 2'b00);
   assign aw_hs      = (state == WR_REQ) && !aw_done && axi.awready;
   assign w_hs       = (state == WR_REQ) && !w_done && axi.wready;
   assign dbg_state  = state;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (misaligned)  state_nxt = DONE;
               else if (req_we) state_nxt = WR_REQ;
               else             state_nxt = RD_REQ;
            end
         end
         // AW and W may finish in either order or together; a channel counts as
         // finished if its flag is set or its handshake is happening right now.
         WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
         WR_RESP: if (axi.bvalid)  state_nxt = DONE;
         RD_REQ:  if (axi.arready) state_nxt = RD_RESP;
         RD_RESP: if (axi.rvalid)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Valids come only from registered state and flags, never from a ready input.
   always_comb begin
      req_ready   = (state == IDLE) && aresetn;
      axi.awvalid = (state == WR_REQ) && !aw_done;
      axi.wvalid  = (state == WR_REQ) && !w_done;
      axi.bready  = (state == WR_RESP);
      axi.arvalid = (state == RD_REQ);
      axi.rready  = (state == RD_RESP);
      axi.awaddr  = addr_q;
      axi.araddr  = addr_q;
      axi.wdata   = wdata_q;
      axi.wstrb   = wstrb_q;
      axi.awprot  = 3'b000;
      axi.arprot  = 3'b000;
      rsp_valid   = (state == DONE);
      rsp_err     = (state == DONE) && err_q;
      rsp_rdata   = ((state == DONE) && !err_q) ? rdata_q : '0;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  wstrb_q <= req_wstrb;
                  rdata_q <= '0;
                  err_q   <= misaligned;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
               end
            end
            WR_REQ: begin
               if (aw_hs) aw_done <= 1'b1;
               if (w_hs)  w_done  <= 1'b1;
            end
            WR_RESP: begin
               if (axi.bvalid) err_q <= resp_is_err(axi.bresp);
            end
            RD_RESP: begin
               if (axi.rvalid) begin
                  rdata_q <= axi.rdata;
                  err_q   <= resp_is_err(axi.rresp);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
